// File: rtl/rect_paint_engine.sv
// Rectangle fill engine: queues rectangle commands, clips each one to the
// screen and writes it to video memory one pixel at a time, row-major, with
// a programmable write-pulse width and inter-pixel gap.
module rect_paint_engine #(
  parameter int SCR_W      = 160,
  parameter int SCR_H      = 120,
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int ADDR_BITS  = 15,
  parameter int COLOR_BITS = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int WR_CYCLES  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_BITS-1:0]     cmd_x_start,
  input  logic [Y_BITS-1:0]     cmd_y_start,
  input  logic [X_BITS-1:0]     cmd_x_end,
  input  logic [Y_BITS-1:0]     cmd_y_end,
  input  logic [COLOR_BITS-1:0] cmd_color,
  input  logic                  flush,
  output logic [ADDR_BITS-1:0]  address,
  output logic [COLOR_BITS-1:0] color,
  output logic                  print_enable,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENT_W   = 2 * X_BITS + 2 * Y_BITS + COLOR_BITS;
  localparam int CNT_MAX = (WR_CYCLES > GAP_CYCLES) ? WR_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]     WR_LOAD    = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0]     GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [X_BITS:0]      SCR_W_C    = (X_BITS + 1)'(SCR_W);
  localparam logic [Y_BITS:0]      SCR_H_C    = (Y_BITS + 1)'(SCR_H);
  localparam logic [ADDR_BITS-1:0] SCR_W_A    = ADDR_BITS'(SCR_W);
  localparam logic [PTR_W:0]       LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_GAP, S_NEXT} state_t;
  state_t state_q, state_d;

  // Command FIFO storage and bookkeeping
  logic [ENT_W-1:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        level_q, level_d;
  logic                  push, pop;
  logic [X_BITS-1:0]     h_xs, h_xe;
  logic [Y_BITS-1:0]     h_ys, h_ye;
  logic [COLOR_BITS-1:0] h_col;

  // Working copy of the command being drawn
  logic [X_BITS-1:0]     xs_q, xs_d, xend_q, xend_d, x_q, x_d, x_last_q, x_last_d;
  logic [Y_BITS-1:0]     ys_q, ys_d, yend_q, yend_d, y_q, y_d, y_last_q, y_last_d;
  logic [COLOR_BITS-1:0] ccol_q, ccol_d, color_q, color_d;
  logic [ADDR_BITS-1:0]  row_base_q, row_base_d, addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pe_q, pe_d, done_q, done_d, busy_q, busy_d;

  // Clipping and first-row arithmetic, only consumed in LOAD
  logic [X_BITS:0]       xe_clip, xe_m1;
  logic [Y_BITS:0]       ye_clip, ye_m1;
  logic                  empty_rect;
  logic [ADDR_BITS-1:0]  row_base_load, row_base_step;

  assign cmd_ready = (level_q < LEVEL_FULL);
  assign push      = cmd_valid && cmd_ready && !flush;
  assign {h_xs, h_ys, h_xe, h_ye, h_col} = fifo_mem_q[rd_ptr_q];

  assign xe_clip = ({1'b0, xend_q} > SCR_W_C) ? SCR_W_C : {1'b0, xend_q};
  assign ye_clip = ({1'b0, yend_q} > SCR_H_C) ? SCR_H_C : {1'b0, yend_q};
  assign xe_m1   = xe_clip - (X_BITS + 1)'(1);
  assign ye_m1   = ye_clip - (Y_BITS + 1)'(1);
  // The off-screen start tests are implied by the clipped ends but kept for clarity
  assign empty_rect = ({1'b0, xs_q} >= xe_clip) || ({1'b0, ys_q} >= ye_clip) ||
                      ({1'b0, xs_q} >= SCR_W_C) || ({1'b0, ys_q} >= SCR_H_C);
  assign row_base_load = ADDR_BITS'(ys_q) * SCR_W_A;
  assign row_base_step = row_base_q + SCR_W_A;

  // Command storage: plain array written on push, no reset required
  always_ff @(posedge Clck) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {cmd_x_start, cmd_y_start, cmd_x_end, cmd_y_end, cmd_color};
  end

  // FIFO pointers and fill level; flush empties the queue outright
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + (PTR_W + 1)'(1);
      else if (pop && !push) level_d = level_q - (PTR_W + 1)'(1);
    end
  end

  // State register together with the datapath and output registers
  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;  wr_ptr_q <= '0;  rd_ptr_q <= '0;  level_q <= '0;
      xs_q <= '0;  ys_q <= '0;  xend_q <= '0;  yend_q <= '0;  ccol_q <= '0;
      x_q <= '0;  y_q <= '0;  x_last_q <= '0;  y_last_q <= '0;
      row_base_q <= '0;  addr_q <= '0;  color_q <= '0;  cnt_q <= '0;
      pe_q <= 1'b0;  done_q <= 1'b0;  busy_q <= 1'b0;
    end else begin
      state_q <= state_d;  wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  level_q <= level_d;
      xs_q <= xs_d;  ys_q <= ys_d;  xend_q <= xend_d;  yend_q <= yend_d;  ccol_q <= ccol_d;
      x_q <= x_d;  y_q <= y_d;  x_last_q <= x_last_d;  y_last_q <= y_last_d;
      row_base_q <= row_base_d;  addr_q <= addr_d;  color_q <= color_d;  cnt_q <= cnt_d;
      pe_q <= pe_d;  done_q <= done_d;  busy_q <= busy_d;
    end
  end

  // Next-state and pixel-walk logic; address advances by add only
  always_comb begin
    state_d = state_q;  pop = 1'b0;
    xs_d = xs_q;  ys_d = ys_q;  xend_d = xend_q;  yend_d = yend_q;  ccol_d = ccol_q;
    x_d = x_q;  y_d = y_q;  x_last_d = x_last_q;  y_last_d = y_last_q;
    row_base_d = row_base_q;  addr_d = addr_q;  color_d = color_q;  cnt_d = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop = 1'b1;
          xs_d = h_xs;  ys_d = h_ys;  xend_d = h_xe;  yend_d = h_ye;  ccol_d = h_col;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (empty_rect) begin
          state_d = S_IDLE;
        end else begin
          x_d = xs_q;  y_d = ys_q;
          x_last_d = xe_m1[X_BITS-1:0];
          y_last_d = ye_m1[Y_BITS-1:0];
          row_base_d = row_base_load;
          addr_d  = row_base_load + ADDR_BITS'(xs_q);
          color_d = ccol_q;
          cnt_d   = WR_LOAD;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (GAP_CYCLES > 0) begin
          cnt_d = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else state_d = S_NEXT;
      end
      S_NEXT: begin
        if (x_q == x_last_q && y_q == y_last_q) begin
          state_d = S_IDLE;
        end else if (x_q == x_last_q) begin
          x_d = xs_q;
          y_d = y_q + Y_BITS'(1);
          row_base_d = row_base_step;
          addr_d  = row_base_step + ADDR_BITS'(xs_q);
          cnt_d   = WR_LOAD;
          state_d = S_WRITE;
        end else begin
          x_d = x_q + X_BITS'(1);
          addr_d  = addr_q + ADDR_BITS'(1);
          cnt_d   = WR_LOAD;
          state_d = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      pop = 1'b0;
    end
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    pe_d   = (state_d == S_WRITE);
    done_d = !flush && (state_d == S_IDLE) && ((state_q == S_LOAD) || (state_q == S_NEXT));
    busy_d = (state_d != S_IDLE) || (level_d != '0);
  end

  assign address      = addr_q;
  assign color        = color_q;
  assign print_enable = pe_q;
  assign done         = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rect_paint_engine.sv
// Bench for rect_paint_engine: directed scenarios plus random rectangles,
// with a pixel-list reference model feeding a scoreboard queue.
module tb_rect_paint_engine;
  localparam int SW = 160, SH = 120, WR = 2, GAP = 1, PERIOD = WR + GAP + 1;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, flush = 1'b0;
  logic        cmd_ready, print_enable, busy, done;
  logic [7:0]  cmd_x_start = '0, cmd_x_end = '0;
  logic [6:0]  cmd_y_start = '0, cmd_y_end = '0;
  logic [2:0]  cmd_color = '0, color;
  logic [14:0] address;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rect_paint_engine dut (
    .Clck(clk), .Reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x_start(cmd_x_start), .cmd_y_start(cmd_y_start), .cmd_x_end(cmd_x_end),
    .cmd_y_end(cmd_y_end), .cmd_color(cmd_color), .flush(flush), .address(address),
    .color(color), .print_enable(print_enable), .busy(busy), .done(done)
  );

  typedef struct {int addr; int col;} wr_t;
  wr_t exp_q[$];
  int  n_cmp = 0, n_err = 0, n_cmd = 0;
  int  exp_done = 0, done_cnt = 0, wr_cnt = 0;
  int  first_rise_cyc = -1, last_done_cyc = -1, last_push_cyc = 0;
  // monitor state
  bit  pe_prev = 0, per_valid = 0, stable = 1;
  int  hi_cnt = 0, last_rise = 0, hold_addr = 0, hold_col = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: every on-screen pixel of the rectangle, row-major
  task automatic model_cmd(input int xs, input int ys, input int xe, input int ye, input int col);
    int xc, yc;
    xc = (xe > SW) ? SW : xe;
    yc = (ye > SH) ? SH : ye;
    for (int y = ys; y < yc; y++)
      for (int x = xs; x < xc; x++)
        exp_q.push_back('{y * SW + x, col});
    exp_done++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input int xs, input int ys, input int xe, input int ye, input int col);
    int t;
    t = 0;
    while (!cmd_ready && t < 3000) begin tick(1); t++; end
    chk("push_ready_timeout", int'(t >= 3000), 0);
    if (t < 3000) begin
      cmd_x_start = 8'(xs);  cmd_y_start = 7'(ys);
      cmd_x_end   = 8'(xe);  cmd_y_end   = 7'(ye);
      cmd_color   = 3'(col); cmd_valid   = 1'b1;
      tick(1);
      last_push_cyc = cyc;
      cmd_valid = 1'b0;
      n_cmd++;
      $display("cmd %0d: (%0d,%0d)-(%0d,%0d) colour %0d", n_cmd, xs, ys, xe, ye, col);
      model_cmd(xs, ys, xe, ye, col);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 8000) begin tick(1); t++; end
    chk("drain_timeout", int'(t >= 8000), 0);
    tick(3);
  endtask

  initial begin : main
    fork
      // Monitor: pops the scoreboard on every write pulse and checks its shape
      forever begin
        @(negedge clk);
        if (rst) begin
          pe_prev = 0; per_valid = 0; hi_cnt = 0;
        end else begin
          if (flush) per_valid = 0;
          if (done) begin done_cnt++; last_done_cyc = cyc; per_valid = 0; end
          if (print_enable && !pe_prev) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_write: got addr %0d colour %0d, required no write", address, color);
            end else begin
              wr_t e;
              e = exp_q.pop_front();
              chk("write_addr", int'(address), e.addr);
              chk("write_colour", int'(color), e.col);
            end
            if (per_valid) chk("pixel_period", cyc - last_rise, PERIOD);
            else first_rise_cyc = cyc;
            last_rise = cyc; per_valid = 1; hi_cnt = 1; stable = 1;
            hold_addr = int'(address); hold_col = int'(color);
          end else if (print_enable) begin
            hi_cnt++;
            if (int'(address) != hold_addr || int'(color) != hold_col) stable = 0;
          end
          if (!print_enable && pe_prev) begin
            chk("pe_width", hi_cnt, WR);
            chk("hold_stable", int'(stable), 1);
          end
          pe_prev = print_enable;
        end
      end
    join_none

    // Reset state
    tick(3);
    chk("rst_pe", int'(print_enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(address), 0);
    chk("rst_colour", int'(color), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    rst = 1'b0;
    tick(2);

    // 1: basic 2x2 rectangle; first write visible after edge N+2, i.e. high at edge N+3
    push_cmd(3, 4, 5, 6, 5);
    chk("busy_after_push", int'(busy), 1);
    drain();
    chk("first_write_latency", first_rise_cyc - last_push_cyc, 2);
    chk("t1_done", done_cnt, exp_done);

    // 2: clipped at the bottom-right corner
    push_cmd(158, 119, 162, 121, 2);
    drain();
    chk("t2_done", done_cnt, exp_done);

    // 3: empty rectangle, done in the cycle after LOAD
    push_cmd(10, 10, 10, 20, 7);
    drain();
    chk("empty_done_latency", last_done_cyc - last_push_cyc, 2);
    chk("t3_done", done_cnt, exp_done);

    // 4: fill the FIFO behind a long rectangle; the fifth push is ignored
    push_cmd(0, 0, 20, 20, 1);
    tick(3);
    for (int i = 0; i < 5; i++) begin
      chk("ready_while_filling", int'(cmd_ready), int'(i < 4));
      cmd_x_start = 8'(i * 3); cmd_y_start = 7'd50;
      cmd_x_end = 8'(i * 3 + 2); cmd_y_end = 7'd51;
      cmd_color = 3'(i + 2); cmd_valid = 1'b1;
      tick(1);
      if (i < 4) begin
        n_cmd++;
        $display("cmd %0d: (%0d,50)-(%0d,51) colour %0d", n_cmd, i * 3, i * 3 + 2, i + 2);
        model_cmd(i * 3, 50, i * 3 + 2, 51, i + 2);
      end
    end
    cmd_valid = 1'b0;
    chk("ready_when_full", int'(cmd_ready), 0);
    drain();
    chk("t4_done", done_cnt, exp_done);

    // 5: asynchronous reset while a pixel is being written
    push_cmd(30, 30, 34, 34, 6);
    begin
      int t;
      t = 0;
      while (!print_enable && t < 50) begin tick(1); t++; end
      chk("wait_first_pe", int'(print_enable), 1);
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_pe", int'(print_enable), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_addr", int'(address), 0);
    chk("arst_ready", int'(cmd_ready), 1);
    exp_q.delete();
    exp_done--;
    @(posedge clk);
    tick(1);
    rst = 1'b0;
    tick(30);
    chk("t5_done", done_cnt, exp_done);

    // 6: flush in row 2 of a 4x4 rectangle with two commands queued behind it
    begin
      int w0, t;
      w0 = wr_cnt;
      push_cmd(20, 20, 24, 24, 3);
      push_cmd(0, 0, 2, 1, 1);
      push_cmd(5, 5, 6, 6, 2);
      t = 0;
      while (wr_cnt < w0 + 5 && t < 100) begin tick(1); t++; end
      chk("wait_row2", wr_cnt - w0, 5);
      t = 0;
      while (print_enable && t < 10) begin tick(1); t++; end
      chk("wait_gap", int'(print_enable), 0);
    end
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_busy", int'(busy), 0);
    chk("flush_pe", int'(print_enable), 0);
    chk("flush_ready", int'(cmd_ready), 1);
    exp_q.delete();
    exp_done -= 3;
    tick(40);
    chk("t6_done", done_cnt, exp_done);

    // Random rectangles, many near or beyond the screen edges
    for (int i = 0; i < 30; i++) begin
      int xs, ys, xe, ye;
      xs = $urandom_range(0, 165);
      ys = $urandom_range(0, 124);
      xe = xs + $urandom_range(0, 6) - 1;
      ye = ys + $urandom_range(0, 5) - 1;
      if (xe < 0) xe = 0;
      if (xe > 255) xe = 255;
      if (ye < 0) ye = 0;
      if (ye > 127) ye = 127;
      push_cmd(xs, ys, xe, ye, $urandom_range(0, 7));
      tick($urandom_range(0, 3));
    end
    drain();
    chk("final_done", done_cnt, exp_done);
    chk("final_queue", exp_q.size(), 0);
    chk("final_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
